wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values are 32 and above.
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have parameter CNT_W, default 32, retire-counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port iValid  in  1  MEM-stage instruction valid.
REQ-007 SHALL have port iStall  in  1  hold the WB register contents.
REQ-008 SHALL have port iFlush  in  1  kill the incoming instruction.
REQ-009 SHALL have port iSig_regfile_write  in  1  instruction writes the register file.
REQ-010 SHALL have port iSig_WbSel  in  2  result source: 00 ALU, 01 memory, 10 PC+4, 11 reserved (treated as ALU).
REQ-011 SHALL have port iLoadType  in  3  load format: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWU, 110/111 reserved (treated as LW).
REQ-012 SHALL have port iread_from_ram  in  DATA_W  memory read data.
REQ-013 SHALL have port ialu_result  in  DATA_W  ALU result; bits [1:0] are the load byte offset.
REQ-014 SHALL have port ipc_plus4  in  DATA_W  link value.
REQ-015 SHALL have port iDest_reg  in  REG_AW  destination register.
REQ-016 SHALL have port odata2write2regfile  out  DATA_W  registered write-back data.
REQ-017 SHALL have port oDest_reg  out  REG_AW  registered destination register.
REQ-018 SHALL have port oSig_RegfileWrite  out  1  register-file write enable.
REQ-019 SHALL have port oValid  out  1  WB register holds a live instruction.
REQ-020 SHALL have port oMisalign  out  1  registered misaligned-load flag.
REQ-021 SHALL have port oRetire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-022 SHALL capture the inputs into the WB register on each edge when iStall=0 and iFlush=0; output latency is 1 cycle.
REQ-023 SHALL, when iFlush=1, load oValid=0 and clear oMisalign regardless of iStall; flush has priority over stall.
REQ-024 SHALL, when iStall=1 and iFlush=0, hold every registered output, including oRetire_cnt, unchanged.
REQ-025 SHALL, for memory loads, use little-endian lanes from iread_from_ram[31:0]: byte lane k is bits [8k+7:8k], k=ialu_result[1:0].
REQ-026 SHALL select the half lane with ialu_result[1] (0 gives bits [15:0], 1 gives bits [31:16]).
REQ-027 SHALL extend loads to DATA_W as follows: LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
REQ-028 SHALL pass ALU and PC+4 sources at full DATA_W without modification.
REQ-029 SHALL flag a misaligned load only when iSig_WbSel=01, under these conditions:
- LH or LHU with ialu_result[0]=1;
- LW or LWU with ialu_result[1:0]!=0.
REQ-030 SHALL, on a misaligned capture, set oMisalign=1 for that instruction, suppress its register write, and still register the data as if aligned.
REQ-031 SHALL drive oSig_RegfileWrite = oValid AND registered write flag AND NOT oMisalign AND (oDest_reg != 0).
REQ-032 SHALL increment oRetire_cnt by 1 on each capture with iValid=1, iStall=0 and iFlush=0, including misaligned and non-writing instructions.
REQ-033 SHALL wrap oRetire_cnt from all-ones to 0 with no flag.
REQ-034 SHALL ignore iLoadType and the byte offset when iSig_WbSel != 01.

Reset
REQ-035 SHALL, on any edge with rstn=0, clear oValid, oSig_RegfileWrite, oMisalign, odata2write2regfile, oDest_reg and oRetire_cnt to 0.
REQ-036 SHALL give reset priority over flush, stall and capture, including when reset is asserted mid-stall.
REQ-037 SHALL resume normal capture on the first edge with rstn=1.

Verification
REQ-038 SHALL cover LB sign-extend: ram=0x1234_80FF, alu=0x...01, WbSel=01, LB, dest=3 -> next cycle data=0xFFFF_FF80, write=1, dest=3.
REQ-039 SHALL cover LHU with misalign: ram=0xBEEF_CAFE, alu[1:0]=2, LHU -> data=0x0000_BEEF; then alu[1:0]=1 -> oMisalign=1, write=0, counter still +1.
REQ-040 SHALL cover stall with simultaneous flush: capture ALU=0x55 (dest 7), then stall=1 with new inputs -> outputs hold 0x55; then stall=1 and flush=1 -> oValid=0, write=0, counter unchanged.
REQ-041 SHALL cover register-0 suppression and the link source: dest=0, write=1 -> oSig_RegfileWrite=0; WbSel=10, pc+4=0x0040_0008, dest=31 -> data=0x0040_0008, write=1.
REQ-042 SHALL cover counter wrap and reset: with CNT_W=4, 16 valid captures -> counter 0; rstn=0 during a stall -> all outputs 0 on the next edge.
REQ-043 SHALL cover DATA_W=64: LW of 0x8000_0000 -> 0xFFFF_FFFF_8000_0000; LWU -> 0x0000_0000_8000_0000.

Source files
------------

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back pipeline register of a RISC-V style core.
//
// Selects the write-back result (ALU, formatted memory load, or PC+4), formats
// sub-word loads from little-endian byte/half lanes, flags misaligned loads,
// and registers everything for the register-file write port. It also counts
// retired instructions.
//
// Parameters
//   DATA_W  datapath width (32 or more)
//   REG_AW  register-file address width
//   CNT_W   retire-counter width
//
// Ports
//   clk                 clock, all state on the rising edge
//   rstn                synchronous active-low reset
//   iValid              MEM-stage instruction valid
//   iStall              hold the WB register contents
//   iFlush              kill the incoming instruction (beats stall)
//   iSig_regfile_write  instruction writes the register file
//   iSig_WbSel          00 ALU, 01 memory, 10 PC+4, 11 ALU
//   iLoadType           000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWU,
//                       110/111 LW
//   iread_from_ram      memory read data (low 32 bits hold the word)
//   ialu_result         ALU result; bits [1:0] are the load byte offset
//   ipc_plus4           link value
//   iDest_reg           destination register
//   odata2write2regfile registered write-back data
//   oDest_reg           registered destination register
//   oSig_RegfileWrite   register-file write enable
//   oValid              WB register holds a live instruction
//   oMisalign           registered misaligned-load flag
//   oRetire_cnt         retired-instruction count (wraps silently)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iValid,
  input  logic              iStall,
  input  logic              iFlush,
  input  logic              iSig_regfile_write,
  input  logic [1:0]        iSig_WbSel,
  input  logic [2:0]        iLoadType,
  input  logic [DATA_W-1:0] iread_from_ram,
  input  logic [DATA_W-1:0] ialu_result,
  input  logic [DATA_W-1:0] ipc_plus4,
  input  logic [REG_AW-1:0] iDest_reg,
  output logic [DATA_W-1:0] odata2write2regfile,
  output logic [REG_AW-1:0] oDest_reg,
  output logic              oSig_RegfileWrite,
  output logic              oValid,
  output logic              oMisalign,
  output logic [CNT_W-1:0]  oRetire_cnt
);

  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;
  localparam logic [2:0] LT_LWU = 3'b101;

  // Little-endian lanes of the low memory word.
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = iread_from_ram[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = iread_from_ram[16*gi +: 16];
    end
  endgenerate

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       word_sel;
  logic [DATA_W-1:0] load_data;
  logic              misalign_next;
  logic [DATA_W-1:0] wb_data_next;

  // Load formatting. Sized casts of signed operands sign-extend; of unsigned
  // operands zero-extend, which also works when DATA_W is exactly 32.
  always_comb begin
    byte_sel  = byte_lane[ialu_result[1:0]];
    half_sel  = half_lane[ialu_result[1]];
    word_sel  = iread_from_ram[31:0];
    load_data = DATA_W'($signed(word_sel));
    case (iLoadType)
      LT_LB:   load_data = DATA_W'($signed(byte_sel));
      LT_LBU:  load_data = DATA_W'(byte_sel);
      LT_LH:   load_data = DATA_W'($signed(half_sel));
      LT_LHU:  load_data = DATA_W'(half_sel);
      LT_LWU:  load_data = DATA_W'(word_sel);
      default: load_data = DATA_W'($signed(word_sel));
    endcase
  end

  // Misalignment only matters for memory results; byte loads never misalign,
  // reserved load types behave like LW.
  always_comb begin
    misalign_next = 1'b0;
    if (iSig_WbSel == WB_MEM) begin
      case (iLoadType)
        LT_LB, LT_LBU: misalign_next = 1'b0;
        LT_LH, LT_LHU: misalign_next = ialu_result[0];
        default:       misalign_next = (ialu_result[1:0] != 2'b00);
      endcase
    end
  end

  always_comb begin
    case (iSig_WbSel)
      WB_MEM:  wb_data_next = load_data;
      WB_PC4:  wb_data_next = ipc_plus4;
      default: wb_data_next = ialu_result;
    endcase
  end

  logic [DATA_W-1:0] data_reg;
  logic [REG_AW-1:0] dest_reg;
  logic              wr_reg;
  logic              valid_reg;
  logic              misalign_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Reset beats flush, flush beats stall. A flushed slot keeps its stale
  // data/destination; only the valid, write and misalign flags are cleared.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_reg     <= '0;
      dest_reg     <= '0;
      wr_reg       <= 1'b0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (iFlush) begin
      valid_reg    <= 1'b0;
      wr_reg       <= 1'b0;
      misalign_reg <= 1'b0;
    end else if (!iStall) begin
      data_reg     <= wb_data_next;
      dest_reg     <= iDest_reg;
      wr_reg       <= iSig_regfile_write;
      valid_reg    <= iValid;
      misalign_reg <= misalign_next;
      if (iValid) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign odata2write2regfile = data_reg;
  assign oDest_reg           = dest_reg;
  assign oValid              = valid_reg;
  assign oMisalign           = misalign_reg;
  assign oRetire_cnt         = cnt_reg;
  assign oSig_RegfileWrite   = valid_reg & wr_reg & ~misalign_reg & (dest_reg != '0);

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, stall, flush, wr;
  logic [1:0]  wbsel;
  logic [2:0]  lt;
  logic [63:0] ram, alu, pc4;
  logic [4:0]  dest;

  logic [31:0] a_data;
  logic [4:0]  a_dest;
  logic        a_wr, a_vld, a_mis;
  logic [3:0]  a_cnt;

  logic [63:0] b_data;
  logic [4:0]  b_dest;
  logic        b_wr, b_vld, b_mis;
  logic [31:0] b_cnt;

  always #5 clk = ~clk;

  // 32-bit datapath with a 4-bit counter (wrap), 64-bit datapath with default counter.
  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) u_dut32 (
    .clk(clk), .rstn(rstn), .iValid(valid), .iStall(stall), .iFlush(flush),
    .iSig_regfile_write(wr), .iSig_WbSel(wbsel), .iLoadType(lt),
    .iread_from_ram(ram[31:0]), .ialu_result(alu[31:0]), .ipc_plus4(pc4[31:0]),
    .iDest_reg(dest), .odata2write2regfile(a_data), .oDest_reg(a_dest),
    .oSig_RegfileWrite(a_wr), .oValid(a_vld), .oMisalign(a_mis), .oRetire_cnt(a_cnt)
  );

  wb_stage #(.DATA_W(64), .REG_AW(5), .CNT_W(32)) u_dut64 (
    .clk(clk), .rstn(rstn), .iValid(valid), .iStall(stall), .iFlush(flush),
    .iSig_regfile_write(wr), .iSig_WbSel(wbsel), .iLoadType(lt),
    .iread_from_ram(ram), .ialu_result(alu), .ipc_plus4(pc4),
    .iDest_reg(dest), .odata2write2regfile(b_data), .oDest_reg(b_dest),
    .oSig_RegfileWrite(b_wr), .oValid(b_vld), .oMisalign(b_mis), .oRetire_cnt(b_cnt)
  );

  typedef struct {
    logic        rstn, valid, stall, flush, wr;
    logic [1:0]  wbsel;
    logic [2:0]  lt;
    logic [63:0] ram, alu, pc4;
    logic [4:0]  dest;
    logic        e_vld, e_wr, e_mis, e_chk;  // e_chk=0: data/dest not checked
    logic [31:0] e_d32;
    logic [63:0] e_d64;
    logic [4:0]  e_dest;
  } vec_t;

  typedef struct {
    logic        vld, wr, mis, chk;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [4:0]  dest;
    logic [3:0]  cnt4;
    logic [31:0] cnt32;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", txn, name, act, exp);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("valid32", {63'd0, a_vld}, {63'd0, e.vld});
        check("valid64", {63'd0, b_vld}, {63'd0, e.vld});
        check("write32", {63'd0, a_wr}, {63'd0, e.wr});
        check("write64", {63'd0, b_wr}, {63'd0, e.wr});
        check("misalign32", {63'd0, a_mis}, {63'd0, e.mis});
        check("misalign64", {63'd0, b_mis}, {63'd0, e.mis});
        check("cnt4", {60'd0, a_cnt}, {60'd0, e.cnt4});
        check("cnt32", {32'd0, b_cnt}, {32'd0, e.cnt32});
        if (e.chk) begin
          check("data32", {32'd0, a_data}, {32'd0, e.d32});
          check("data64", b_data, e.d64);
          check("dest32", {59'd0, a_dest}, {59'd0, e.dest});
          check("dest64", {59'd0, b_dest}, {59'd0, e.dest});
        end
        $display("txn %0d: vld=%0b wr=%0b mis=%0b d32=0x%08h d64=0x%016h dest=%0d cnt4=%0d cnt32=%0d",
                 txn, a_vld, a_wr, a_mis, a_data, b_data, a_dest, a_cnt, b_cnt);
        txn++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [3:0]  m_cnt4  = '0;
    logic [31:0] m_cnt32 = '0;
    exp_t e;
    int wait_cycles;

    //            rstn valid stall flush wr wbsel lt ram alu pc4 dest | vld wr mis chk d32 d64 dest
    // reset with live inputs, then reset while stalled and flushed
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h77,64'h0,5'd5, 1'b0,1'b0,1'b0,1'b1,32'h0,64'h0,5'd0});
    vecs.push_back('{1'b0,1'b1,1'b1,1'b1,1'b1,2'b01,3'd0,64'h0,64'h2,64'h0,5'd5, 1'b0,1'b0,1'b0,1'b1,32'h0,64'h0,5'd0});
    // LB sign-extend from byte lane 1
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd1,64'h1234_80FF,64'h1,64'h0,5'd3, 1'b1,1'b1,1'b0,1'b1,32'hFFFF_FF80,64'hFFFF_FFFF_FFFF_FF80,5'd3});
    // LHU upper half, then LHU misaligned (still counts, no write, data as aligned)
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd4,64'hBEEF_CAFE,64'h2,64'h0,5'd4, 1'b1,1'b1,1'b0,1'b1,32'h0000_BEEF,64'h0000_BEEF,5'd4});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd4,64'hBEEF_CAFE,64'h1,64'h0,5'd5, 1'b1,1'b0,1'b1,1'b1,32'h0000_CAFE,64'h0000_CAFE,5'd5});
    // ALU 0x55 to dest 7; load type/offset ignored for ALU source
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'd3,64'h0,64'hA5A5_0000_0000_0055,64'h0,5'd7, 1'b1,1'b1,1'b0,1'b1,32'h55,64'hA5A5_0000_0000_0055,5'd7});
    // stall with new inputs holds; stall+flush kills, counter unchanged
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b1,2'b00,3'd0,64'h0,64'h99,64'h0,5'd9, 1'b1,1'b1,1'b0,1'b1,32'h55,64'hA5A5_0000_0000_0055,5'd7});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b1,2'b00,3'd0,64'h0,64'h99,64'h0,5'd9, 1'b0,1'b0,1'b0,1'b0,32'h0,64'h0,5'd0});
    // LW misaligned, then flush clears the flag
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd0,64'h1111_2222,64'h2,64'h0,5'd6, 1'b1,1'b0,1'b1,1'b1,32'h1111_2222,64'h1111_2222,5'd6});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,1'b1,2'b01,3'd0,64'h1111_2222,64'h2,64'h0,5'd6, 1'b0,1'b0,1'b0,1'b0,32'h0,64'h0,5'd0});
    // register 0 suppression, link source, reserved WbSel as ALU
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h1234,64'h0,5'd0, 1'b1,1'b0,1'b0,1'b1,32'h1234,64'h1234,5'd0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b10,3'd0,64'h0,64'h3,64'h0000_0001_0040_0008,5'd31, 1'b1,1'b1,1'b0,1'b1,32'h0040_0008,64'h0000_0001_0040_0008,5'd31});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b11,3'd1,64'h0,64'hDEAD_BEEF,64'h0,5'd2, 1'b1,1'b1,1'b0,1'b1,32'hDEAD_BEEF,64'hDEAD_BEEF,5'd2});
    // LW / LWU of 0x8000_0000 (upper RAM bits are ignored)
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd0,64'h1234_5678_8000_0000,64'h0,64'h0,5'd8, 1'b1,1'b1,1'b0,1'b1,32'h8000_0000,64'hFFFF_FFFF_8000_0000,5'd8});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd5,64'h1234_5678_8000_0000,64'h0,64'h0,5'd8, 1'b1,1'b1,1'b0,1'b1,32'h8000_0000,64'h0000_0000_8000_0000,5'd8});
    // LH upper half sign-extend, LBU lane 3
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd3,64'h8001_7FFF,64'h2,64'h0,5'd10, 1'b1,1'b1,1'b0,1'b1,32'hFFFF_8001,64'hFFFF_FFFF_FFFF_8001,5'd10});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd2,64'h9A00_0000,64'h3,64'h0,5'd11, 1'b1,1'b1,1'b0,1'b1,32'h0000_009A,64'h0000_009A,5'd11});
    // bubble: captured but not live, not counted
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h7,64'h0,5'd1, 1'b0,1'b0,1'b0,1'b1,32'h7,64'h7,5'd1});
    // reserved load type behaves as LW
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,3'd6,64'hF000_0001,64'h0,64'h0,5'd12, 1'b1,1'b1,1'b0,1'b1,32'hF000_0001,64'hFFFF_FFFF_F000_0001,5'd12});
    // drive the 4-bit counter through its wrap
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h10,64'h0,5'd12, 1'b1,1'b1,1'b0,1'b1,32'h10,64'h10,5'd12});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h11,64'h0,5'd12, 1'b1,1'b1,1'b0,1'b1,32'h11,64'h11,5'd12});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h12,64'h0,5'd12, 1'b1,1'b1,1'b0,1'b1,32'h12,64'h12,5'd12});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h13,64'h0,5'd12, 1'b1,1'b1,1'b0,1'b1,32'h13,64'h13,5'd12});
    // stall, then reset during stall, then resume
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b1,2'b00,3'd0,64'h0,64'h20,64'h0,5'd13, 1'b1,1'b1,1'b0,1'b1,32'h13,64'h13,5'd12});
    vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b1,2'b00,3'd0,64'h0,64'h20,64'h0,5'd13, 1'b0,1'b0,1'b0,1'b1,32'h0,64'h0,5'd0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'd0,64'h0,64'h42,64'h0,5'd1, 1'b1,1'b1,1'b0,1'b1,32'h42,64'h42,5'd1});

    rstn = 1'b0; valid = 1'b0; stall = 1'b0; flush = 1'b0; wr = 1'b0;
    wbsel = 2'b00; lt = 3'd0; ram = '0; alu = '0; pc4 = '0; dest = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rstn  = vecs[i].rstn;  valid = vecs[i].valid; stall = vecs[i].stall;
      flush = vecs[i].flush; wr    = vecs[i].wr;    wbsel = vecs[i].wbsel;
      lt    = vecs[i].lt;    ram   = vecs[i].ram;   alu   = vecs[i].alu;
      pc4   = vecs[i].pc4;   dest  = vecs[i].dest;
      // retire-counter reference: reset clears, live capture increments
      if (!vecs[i].rstn) begin
        m_cnt4 = '0; m_cnt32 = '0;
      end else if (vecs[i].valid && !vecs[i].stall && !vecs[i].flush) begin
        m_cnt4 = m_cnt4 + 4'd1; m_cnt32 = m_cnt32 + 32'd1;
      end
      e.vld = vecs[i].e_vld; e.wr = vecs[i].e_wr; e.mis = vecs[i].e_mis; e.chk = vecs[i].e_chk;
      e.d32 = vecs[i].e_d32; e.d64 = vecs[i].e_d64; e.dest = vecs[i].e_dest;
      e.cnt4 = m_cnt4; e.cnt32 = m_cnt32;
      sb.push_back(e);
    end

    @(negedge clk);
    stall = 1'b1;
    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected records left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
